// File: rtl/fbu_pkg.sv
// fbu_pkg
// Shared types and constants for the fetch/branch unit: op and condition
// encodings, FSM state type, fault codes, flag bit positions and the
// condition evaluation helper used when resolving JCC.
package fbu_pkg;

    typedef enum logic [2:0] {
        OP_SEQ  = 3'd0,
        OP_JMP  = 3'd1,
        OP_JCC  = 3'd2,
        OP_CALL = 3'd3,
        OP_RET  = 3'd4,
        OP_JREG = 3'd5
    } fbu_op_t;

    typedef enum logic [3:0] {
        COND_Z  = 4'd0,
        COND_B  = 4'd1,
        COND_BE = 4'd2,
        COND_A  = 4'd3,
        COND_AE = 4'd4,
        COND_G  = 4'd5,
        COND_GE = 4'd6,
        COND_L  = 4'd7,
        COND_LE = 4'd8
    } fbu_cond_t;

    typedef enum logic [1:0] {
        ST_FETCH0 = 2'd0,
        ST_FETCH1 = 2'd1,
        ST_DECODE = 2'd2,
        ST_FAULT  = 2'd3
    } fbu_state_t;

    localparam logic [1:0] FAULT_NONE      = 2'b00;
    localparam logic [1:0] FAULT_OVERFLOW  = 2'b01;
    localparam logic [1:0] FAULT_UNDERFLOW = 2'b10;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_S = 1;
    localparam int FLAG_O = 0;

    // Evaluates a branch condition against Z/C/S/O; unused encodings are
    // never taken.
    function automatic logic cond_taken(input logic [3:0] cond, input logic [3:0] flags);
        logic z, c, s, o, taken;
        z = flags[FLAG_Z];
        c = flags[FLAG_C];
        s = flags[FLAG_S];
        o = flags[FLAG_O];
        taken = 1'b0;
        case (cond)
            COND_Z:  taken = z;
            COND_B:  taken = c;
            COND_BE: taken = c | z;
            COND_A:  taken = !c && !z;
            COND_AE: taken = !c;
            COND_G:  taken = !z && (s == o);
            COND_GE: taken = (s == o);
            COND_L:  taken = (s != o);
            COND_LE: taken = z || (s != o);
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/fbu_return_stack.sv
// fbu_return_stack
// Parametrised LIFO holding return addresses for CALL/RET.
// Ports:
//   clk, rst (async active-low)
//   push, push_data : write push_data on top (ignored when full)
//   pop             : discard top entry (ignored when empty)
//   top             : current top entry (zero when empty)
//   full, empty, count : occupancy status
module fbu_return_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic                           pop,
    input  logic [WIDTH-1:0]               push_data,
    output logic [WIDTH-1:0]               top,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    // A depth of one still needs a one-bit entry index.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] entries [DEPTH];
    logic [CNT_W-1:0] top_idx;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign top_idx = count - CNT_W'(1);
    assign top     = empty ? '0 : entries[top_idx[PTR_W-1:0]];

    // Occupancy counter; the owner never pushes and pops in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (push && !full) begin
            count <= count + CNT_W'(1);
        end else if (pop && !empty) begin
            count <= count - CNT_W'(1);
        end
    end

    // Entry storage needs no reset: count alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            entries[count[PTR_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_branch_unit.sv
// fetch_branch_unit
// Owns the PC, fetches the two-word instruction window (pc, pc+1) over a
// req/ack memory handshake, and resolves SEQ/JMP/JCC/CALL/RET/JREG ops from
// the control unit using a hardware return-address stack.
// Ports:
//   clk, rst (async active-low)
//   imem_req/imem_addr/imem_ack/imem_rdata : instruction memory handshake
//   instr_valid, instr_w0, instr_w1       : decoded window to control unit
//   pc                                     : current program counter
//   op_valid/op_ready, op_code, op_len, op_cond, op_target, flags : op issue
//   stack_count                            : return stack occupancy
//   fault, fault_code                      : sticky stack fault report
//   taken_count, nottaken_count            : JCC outcome statistics
// Optional feature: define FBU_BRANCH_STATS_EN to build the saturating
// JCC statistics counters; otherwise both statistics ports read zero.
module fetch_branch_unit
    import fbu_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 16,
    parameter int                    INSTR_WIDTH  = 16,
    parameter int                    STACK_DEPTH  = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    output logic                             imem_req,
    output logic [ADDR_WIDTH-1:0]            imem_addr,
    input  logic                             imem_ack,
    input  logic [INSTR_WIDTH-1:0]           imem_rdata,
    output logic                             instr_valid,
    output logic [INSTR_WIDTH-1:0]           instr_w0,
    output logic [INSTR_WIDTH-1:0]           instr_w1,
    output logic [ADDR_WIDTH-1:0]            pc,
    input  logic                             op_valid,
    output logic                             op_ready,
    input  logic [2:0]                       op_code,
    input  logic                             op_len,
    input  logic [3:0]                       op_cond,
    input  logic [ADDR_WIDTH-1:0]            op_target,
    input  logic [3:0]                       flags,
    output logic [$clog2(STACK_DEPTH+1)-1:0] stack_count,
    output logic                             fault,
    output logic [1:0]                       fault_code,
    output logic [15:0]                      taken_count,
    output logic [15:0]                      nottaken_count
);

    fbu_state_t            state;
    logic [ADDR_WIDTH-1:0] seq_pc;
    logic [ADDR_WIDTH-1:0] next_pc;
    logic [ADDR_WIDTH-1:0] stack_top;
    logic                  stack_full;
    logic                  stack_empty;
    logic                  accept;
    logic                  taken;
    logic                  is_call;
    logic                  is_ret;
    logic                  push;
    logic                  pop;
    logic                  overflow;
    logic                  underflow;

    assign accept    = (state == ST_DECODE) && op_valid;
    assign is_call   = (op_code == OP_CALL);
    assign is_ret    = (op_code == OP_RET);
    assign push      = accept && is_call && !stack_full;
    assign pop       = accept && is_ret && !stack_empty;
    assign overflow  = accept && is_call && stack_full;
    assign underflow = accept && is_ret && stack_empty;

    // FETCH1 reads the second word; the address wraps naturally at 2^ADDR_WIDTH.
    assign imem_addr = (state == ST_FETCH1) ? pc + ADDR_WIDTH'(1) : pc;

    // Successor PC for the op currently offered; only used on acceptance.
    always_comb begin
        seq_pc  = pc + ADDR_WIDTH'(1) + ADDR_WIDTH'(op_len);
        taken   = cond_taken(op_cond, flags);
        next_pc = seq_pc;
        case (op_code)
            OP_JMP, OP_JREG: next_pc = op_target;
            OP_JCC:          next_pc = taken ? op_target : seq_pc;
            OP_CALL:         next_pc = op_target;
            OP_RET:          next_pc = stack_top;
            default:         next_pc = seq_pc;
        endcase
    end

    fbu_return_stack #(
        .WIDTH (ADDR_WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (seq_pc),
        .top       (stack_top),
        .full      (stack_full),
        .empty     (stack_empty),
        .count     (stack_count)
    );

    // Main fetch/decode FSM with registered handshake outputs. Coming out of
    // reset imem_req is low in FETCH0, so the first cycle only raises it and
    // any stray ack seen before the request is up is ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_FETCH0;
            pc          <= RESET_VECTOR;
            instr_w0    <= '0;
            instr_w1    <= '0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            op_ready    <= 1'b0;
            fault       <= 1'b0;
            fault_code  <= FAULT_NONE;
        end else begin
            case (state)
                ST_FETCH0: begin
                    if (!imem_req) begin
                        imem_req <= 1'b1;
                    end else if (imem_ack) begin
                        instr_w0 <= imem_rdata;
                        state    <= ST_FETCH1;
                    end
                end
                ST_FETCH1: begin
                    if (imem_ack) begin
                        instr_w1    <= imem_rdata;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                        op_ready    <= 1'b1;
                        state       <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (op_valid) begin
                        instr_valid <= 1'b0;
                        op_ready    <= 1'b0;
                        if (overflow || underflow) begin
                            fault      <= 1'b1;
                            fault_code <= overflow ? FAULT_OVERFLOW : FAULT_UNDERFLOW;
                            state      <= ST_FAULT;
                        end else begin
                            pc       <= next_pc;
                            imem_req <= 1'b1;
                            state    <= ST_FETCH0;
                        end
                    end
                end
                ST_FAULT: begin
                end
                default: state <= ST_FAULT;
            endcase
        end
    end

`ifdef FBU_BRANCH_STATS_EN
    logic jcc_accept;
    assign jcc_accept = accept && (op_code == OP_JCC);

    // Saturating JCC outcome counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            taken_count    <= '0;
            nottaken_count <= '0;
        end else if (jcc_accept) begin
            if (taken) begin
                if (taken_count != 16'hFFFF) taken_count <= taken_count + 16'd1;
            end else begin
                if (nottaken_count != 16'hFFFF) nottaken_count <= nottaken_count + 16'd1;
            end
        end
    end
`else
    assign taken_count    = '0;
    assign nottaken_count = '0;
`endif

endmodule
